// File: rtl/lfsr_cipher_pkg.sv
// Shared types and helpers for the LFSR stream cipher.
package lfsr_cipher_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      OUT
   } state_t;

   localparam logic [63:0] DEFAULT_SEED = 64'ha845fd7183ad75c4;
   localparam logic [63:0] DEFAULT_TAPS = 64'h1B;

   // Key arrives zero-extended, so bits above the key width pass through untouched.
   function automatic logic [31:0] xor_low(input logic [31:0] data, input logic [31:0] key);
      return data ^ key;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Right-shifting Fibonacci LFSR with seed load; an all-zero seed is replaced by SEED.
module lfsr_core #(
   parameter int unsigned   LFSR_W = 64,
   parameter logic [LFSR_W-1:0] TAPS = 64'h1B,
   parameter logic [LFSR_W-1:0] SEED = 64'ha845fd7183ad75c4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              shift,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED;
      end else if (load) begin
         q <= (seed == '0) ? SEED : seed;
      end else if (shift) begin
         q <= {^(q & TAPS), q[LFSR_W-1:1]};
      end
   end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream cipher: valid/ready character in, STEPS LFSR shifts, ciphered character out.
// Optional bypass input enabled by defining LFSR_CIPHER_BYPASS_EN.
module lfsr_stream_cipher
   import lfsr_cipher_pkg::*;
#(
   parameter int unsigned       LFSR_W = 64,
   parameter int unsigned       DATA_W = 8,
   parameter int unsigned       KEY_W  = 6,
   parameter int unsigned       STEPS  = 6,
   parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS,
   parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
`ifdef LFSR_CIPHER_BYPASS_EN
   input  logic              bypass,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [KEY_W-1:0]  key,
   output logic              busy
);

   localparam int unsigned     CNT_W = $clog2(STEPS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  data_q;
   logic               bypass_q;
   logic [LFSR_W-1:0]  lfsr_q;
   logic               shift;
   logic [DATA_W-1:0]  cipher;

   assign shift = (state == STEP) && !seed_load;
   assign key   = lfsr_q[LFSR_W-1 -: KEY_W];

   lfsr_core #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS),
      .SEED   (SEED)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .load  (seed_load),
      .seed  (seed_in),
      .shift (shift),
      .q     (lfsr_q)
   );

   always_comb begin
      cipher = DATA_W'(xor_low(32'(data_q), 32'(key)));
      if (bypass_q) cipher = data_q;
   end

   // Key settles on the final shift edge, so the result is formed from the held
   // character and the live key while out_valid is high; key cannot move in OUT.
   assign out_data = out_valid ? cipher : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cnt       <= '0;
         data_q    <= '0;
         bypass_q  <= 1'b0;
      end else if (seed_load) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  data_q   <= in_data;
`ifdef LFSR_CIPHER_BYPASS_EN
                  bypass_q <= bypass;
`else
                  bypass_q <= 1'b0;
`endif
                  cnt      <= '0;
                  state    <= STEP;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            STEP: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= OUT;
                  out_valid <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
